// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_pkg;

    // Default widths of the writeback path.
    localparam int WB_REG_ID_WIDTH = 5;
    localparam int WB_DATA_WIDTH   = 64;

    // Register 0 is hard-wired; writes to it are dropped.
    localparam int REG_ZERO = 0;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [WB_REG_ID_WIDTH-1:0] dest;
        logic [WB_DATA_WIDTH-1:0]   data;
    } wb_req_t;

    // PASS: pipeline owns the port and the queue drains on idle cycles.
    // DRAIN: the pipeline is stalled and the queue empties one entry per cycle.
    typedef enum logic {
        PASS  = 1'b0,
        DRAIN = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the WB-stage, long-latency and register-file signals around the arbiter.
interface wb_port_arbiter_if #(
    parameter int REG_ID_WIDTH = 5,
    parameter int DATA_WIDTH   = 64
);
    logic                    wb_valid_in;
    logic                    wb_reg_write_in;
    logic [REG_ID_WIDTH-1:0] wb_dest_in;
    logic [DATA_WIDTH-1:0]   wb_data_in;
    logic                    ll_valid_in;
    logic                    ll_ready_out;
    logic [REG_ID_WIDTH-1:0] ll_dest_in;
    logic [DATA_WIDTH-1:0]   ll_data_in;
    logic                    rf_we_out;
    logic [REG_ID_WIDTH-1:0] rf_waddr_out;
    logic [DATA_WIDTH-1:0]   rf_wdata_out;
    logic                    pipe_stall_out;

    // Pipeline / long-latency unit side.
    modport master (
        output wb_valid_in, wb_reg_write_in, wb_dest_in, wb_data_in,
        output ll_valid_in, ll_dest_in, ll_data_in,
        input  ll_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out, pipe_stall_out
    );

    // Arbiter side.
    modport slave (
        input  wb_valid_in, wb_reg_write_in, wb_dest_in, wb_data_in,
        input  ll_valid_in, ll_dest_in, ll_data_in,
        output ll_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out, pipe_stall_out
    );
endinterface

// File: rtl/wb_ll_fifo.sv
// Circular queue of long-latency results; any depth >= 1, pointers wrap modulo DEPTH.
module wb_ll_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  T              i_push_data,
    input  logic          i_pop,
    output T              o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a long-latency unit.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int REG_ID_WIDTH = WB_REG_ID_WIDTH,
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int MAX_WAIT     = 8
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [REG_ID_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]   data;
    } req_t;

    req_t              w_push_data;
    req_t              w_head;
    logic              w_wb_req;
    logic              w_ll_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_grant_pipe;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic [AW-1:0]     w_age_next;
    wb_arb_state_e     w_state_next;

    wb_arb_state_e           r_state;
    logic [AW-1:0]           r_age;
    logic                    r_rf_we;
    logic [REG_ID_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]   r_rf_wdata;
    logic                    r_stall;

    assign w_wb_req  = bus.wb_valid_in & bus.wb_reg_write_in
                     & (bus.wb_dest_in != REG_ID_WIDTH'(REG_ZERO));
    assign bus.ll_ready_out = !reset & !w_full;
    assign w_ll_fire   = bus.ll_valid_in & bus.ll_ready_out;
    // Results aimed at register 0 complete the handshake but are dropped.
    assign w_push      = w_ll_fire & (bus.ll_dest_in != REG_ID_WIDTH'(REG_ZERO));
    assign w_push_data = '{dest: bus.ll_dest_in, data: bus.ll_data_in};

    wb_ll_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Grant selection, post-update occupancy, head age and next FSM state.
    always_comb begin
        w_grant_pipe = 1'b0;
        w_pop        = 1'b0;
        if (r_state == PASS) begin
            if (w_wb_req) begin
                w_grant_pipe = 1'b1;
            end else if (!w_empty) begin
                w_pop = 1'b1;
            end
        end else begin
            w_pop = !w_empty;
        end

        w_count_next = w_count + CW'(w_push) - CW'(w_pop);

        if (w_empty || w_pop) begin
            w_age_next = '0;
        end else if (r_age == AW'(MAX_WAIT)) begin
            w_age_next = r_age;
        end else begin
            w_age_next = r_age + AW'(1);
        end

        w_state_next = r_state;
        if (r_state == PASS) begin
            if ((w_count_next == CW'(FIFO_DEPTH)) ||
                ((w_age_next == AW'(MAX_WAIT)) && (w_count_next != '0))) begin
                w_state_next = DRAIN;
            end
        end else if (w_count_next == '0) begin
            w_state_next = PASS;
        end
    end

    // FSM with registered write-port and stall outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PASS;
            r_age      <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_age   <= w_age_next;
            r_stall <= (w_state_next == DRAIN);
            r_rf_we <= w_grant_pipe | w_pop;
            if (w_grant_pipe) begin
                r_rf_waddr <= bus.wb_dest_in;
                r_rf_wdata <= bus.wb_data_in;
            end else if (w_pop) begin
                r_rf_waddr <= w_head.dest;
                r_rf_wdata <= w_head.data;
            end
        end
    end

    assign bus.rf_we_out      = r_rf_we;
    assign bus.rf_waddr_out   = r_rf_waddr;
    assign bus.rf_wdata_out   = r_rf_wdata;
    assign bus.pipe_stall_out = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int RW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int MAXW  = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wb_port_arbiter_if #(.REG_ID_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

    wb_port_arbiter #(
        .REG_ID_WIDTH (RW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [RW-1:0] dest;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    bit            m_drain;
    int            m_age;
    bit            exp_we;
    logic [RW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    bit            exp_stall;

    always @(posedge clk) begin : model
        int   sz;
        int   new_age;
        bit   wbreq;
        bit   push;
        bit   pop;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_drain   <= 1'b0;
            m_age     <= 0;
            exp_we    <= 1'b0;
            exp_waddr <= '0;
            exp_wdata <= '0;
            exp_stall <= 1'b0;
        end else begin
            sz    = mq.size();
            wbreq = bus.wb_valid_in && bus.wb_reg_write_in && (bus.wb_dest_in != 0);
            push  = bus.ll_valid_in && (sz < DEPTH) && (bus.ll_dest_in != 0);
            pop   = 1'b0;
            exp_we <= 1'b0;
            if (!m_drain && wbreq) begin
                exp_we    <= 1'b1;
                exp_waddr <= bus.wb_dest_in;
                exp_wdata <= bus.wb_data_in;
            end else if (sz > 0) begin
                e = mq.pop_front();
                pop = 1'b1;
                exp_we    <= 1'b1;
                exp_waddr <= e.dest;
                exp_wdata <= e.data;
            end
            if (push) mq.push_back('{bus.ll_dest_in, bus.ll_data_in});
            if (sz == 0 || pop) new_age = 0;
            else new_age = (m_age + 1 > MAXW) ? MAXW : m_age + 1;
            m_age <= new_age;
            if (m_drain) begin
                m_drain   <= (mq.size() != 0);
                exp_stall <= (mq.size() != 0);
            end else begin
                m_drain   <= (mq.size() == DEPTH) || (new_age == MAXW && mq.size() > 0);
                exp_stall <= (mq.size() == DEPTH) || (new_age == MAXW && mq.size() > 0);
            end
        end
    end

    function automatic bit exp_ready();
        return !reset && (mq.size() < DEPTH);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wb_valid_in     = 1'b0;
        bus.wb_reg_write_in = 1'b0;
        bus.wb_dest_in      = '0;
        bus.wb_data_in      = '0;
        bus.ll_valid_in     = 1'b0;
        bus.ll_dest_in      = '0;
        bus.ll_data_in      = '0;
    endtask

    task automatic set_wb(input logic [RW-1:0] d, input logic [DW-1:0] v);
        bus.wb_valid_in     = 1'b1;
        bus.wb_reg_write_in = 1'b1;
        bus.wb_dest_in      = d;
        bus.wb_data_in      = v;
    endtask

    task automatic set_ll(input logic [RW-1:0] d, input logic [DW-1:0] v);
        bus.ll_valid_in = 1'b1;
        bus.ll_dest_in  = d;
        bus.ll_data_in  = v;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (bus.rf_we_out !== 1'b0 || bus.rf_waddr_out !== '0 || bus.rf_wdata_out !== '0) begin
            failures++;
            $display("FAIL reset_rf got we=%b addr=%0d data=%h required all 0",
                     bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        checks++;
        if (bus.pipe_stall_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b required=0", bus.pipe_stall_out);
        end
        checks++;
        if (bus.ll_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_in_reset got=%b required=0", bus.ll_ready_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.ll_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after got=%b required=1", bus.ll_ready_out);
        end
        $display("test_reset done");
    endtask

    task automatic test_pipe_write();
        tick();
        set_wb(5'd5, 64'hAA);
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b1 || bus.rf_waddr_out !== 5'd5 || bus.rf_wdata_out !== 64'hAA) begin
            failures++;
            $display("FAIL pipe_write got we=%b addr=%0d data=%h required we=1 addr=5 data=aa",
                     bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        checks++;
        if (bus.pipe_stall_out !== 1'b0) begin
            failures++;
            $display("FAIL pipe_write_stall got=%b required=0", bus.pipe_stall_out);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b0) begin
            failures++;
            $display("FAIL pipe_write_idle got we=%b required=0", bus.rf_we_out);
        end
        $display("test_pipe_write done");
    endtask

    task automatic test_ll_latency();
        set_ll(5'd7, 64'h11);
        #1;
        checks++;
        if (bus.ll_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL ll_ready_empty got=%b required=1", bus.ll_ready_out);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rf_we_out !== 1'b0) begin
            failures++;
            $display("FAIL ll_lat_early got we=%b required=0", bus.rf_we_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b1 || bus.rf_waddr_out !== 5'd7 || bus.rf_wdata_out !== 64'h11) begin
            failures++;
            $display("FAIL ll_lat_write got we=%b addr=%0d data=%h required we=1 addr=7 data=11",
                     bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b0) begin
            failures++;
            $display("FAIL ll_lat_after got we=%b required=0", bus.rf_we_out);
        end
        $display("test_ll_latency done");
    endtask

    task automatic test_full_drain();
        set_wb(5'd3, 64'h33);
        set_ll(5'd9, 64'h91);
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b1 || bus.rf_waddr_out !== 5'd3) begin
            failures++;
            $display("FAIL full_pipe1 got we=%b addr=%0d required we=1 addr=3",
                     bus.rf_we_out, bus.rf_waddr_out);
        end
        set_ll(5'd10, 64'hA2);
        tick();
        checks++;
        if (bus.ll_ready_out !== 1'b0 || bus.pipe_stall_out !== 1'b1) begin
            failures++;
            $display("FAIL full_enter got ready=%b stall=%b required ready=0 stall=1",
                     bus.ll_ready_out, bus.pipe_stall_out);
        end
        bus.ll_valid_in = 1'b0;
        tick();
        checks++;
        if (bus.pipe_stall_out !== 1'b1 || bus.rf_we_out !== 1'b1 ||
            bus.rf_waddr_out !== 5'd9 || bus.rf_wdata_out !== 64'h91) begin
            failures++;
            $display("FAIL full_drain1 got stall=%b we=%b addr=%0d data=%h required 1 1 9 91",
                     bus.pipe_stall_out, bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        tick();
        checks++;
        if (bus.pipe_stall_out !== 1'b0 || bus.rf_we_out !== 1'b1 ||
            bus.rf_waddr_out !== 5'd10 || bus.rf_wdata_out !== 64'hA2) begin
            failures++;
            $display("FAIL full_drain2 got stall=%b we=%b addr=%0d data=%h required 0 1 10 a2",
                     bus.pipe_stall_out, bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b1 || bus.rf_waddr_out !== 5'd3 || bus.rf_wdata_out !== 64'h33) begin
            failures++;
            $display("FAIL full_replay got we=%b addr=%0d data=%h required 1 3 33",
                     bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        idle_inputs();
        tick();
        $display("test_full_drain done");
    endtask

    task automatic test_age();
        int first_stall;
        int pipe_writes;
        first_stall = -1;
        pipe_writes = 0;
        set_wb(5'd4, 64'h44);
        set_ll(5'd12, 64'hC);
        for (int i = 1; i <= 20 && first_stall < 0; i++) begin
            tick();
            bus.ll_valid_in = 1'b0;
            if (bus.rf_we_out === 1'b1 && bus.rf_waddr_out === 5'd4) pipe_writes++;
            if (bus.pipe_stall_out === 1'b1) first_stall = i;
        end
        checks++;
        if (first_stall != 9) begin
            failures++;
            $display("FAIL age_stall_cycle got=%0d required=9", first_stall);
        end
        checks++;
        if (pipe_writes != 9) begin
            failures++;
            $display("FAIL age_pipe_writes got=%0d required=9", pipe_writes);
        end
        tick();
        checks++;
        if (bus.pipe_stall_out !== 1'b0 || bus.rf_we_out !== 1'b1 ||
            bus.rf_waddr_out !== 5'd12 || bus.rf_wdata_out !== 64'hC) begin
            failures++;
            $display("FAIL age_drain got stall=%b we=%b addr=%0d data=%h required 0 1 12 c",
                     bus.pipe_stall_out, bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b1 || bus.rf_waddr_out !== 5'd4 || bus.rf_wdata_out !== 64'h44) begin
            failures++;
            $display("FAIL age_replay got we=%b addr=%0d data=%h required 1 4 44",
                     bus.rf_we_out, bus.rf_waddr_out, bus.rf_wdata_out);
        end
        idle_inputs();
        tick();
        $display("test_age done");
    endtask

    task automatic test_dest_zero();
        set_wb(5'd0, 64'h55);
        set_ll(5'd0, 64'h66);
        #1;
        checks++;
        if (bus.ll_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL dz_ready got=%b required=1", bus.ll_ready_out);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rf_we_out !== 1'b0 || bus.ll_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL dz_first got we=%b ready=%b required we=0 ready=1",
                     bus.rf_we_out, bus.ll_ready_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b0) begin
            failures++;
            $display("FAIL dz_no_queue_write got we=%b required=0", bus.rf_we_out);
        end
        $display("test_dest_zero done");
    endtask

    task automatic test_reset_in_drain();
        set_wb(5'd2, 64'h22);
        set_ll(5'd13, 64'hD1);
        tick();
        set_ll(5'd14, 64'hE2);
        tick();
        bus.ll_valid_in = 1'b0;
        tick();
        checks++;
        if (bus.pipe_stall_out !== 1'b1 || bus.rf_waddr_out !== 5'd13) begin
            failures++;
            $display("FAIL rd_setup got stall=%b addr=%0d required stall=1 addr=13",
                     bus.pipe_stall_out, bus.rf_waddr_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.pipe_stall_out !== 1'b0 || bus.rf_we_out !== 1'b0 || bus.ll_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL rd_reset got stall=%b we=%b ready=%b required 0 0 0",
                     bus.pipe_stall_out, bus.rf_we_out, bus.ll_ready_out);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (bus.ll_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL rd_ready_after got=%b required=1", bus.ll_ready_out);
        end
        tick();
        checks++;
        if (bus.rf_we_out !== 1'b0 || bus.pipe_stall_out !== 1'b0) begin
            failures++;
            $display("FAIL rd_fifo_empty got we=%b stall=%b required 0 0",
                     bus.rf_we_out, bus.pipe_stall_out);
        end
        $display("test_reset_in_drain done");
    endtask

    task automatic test_random();
        bit ll_pending;
        ll_pending = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            checks++;
            if (bus.rf_we_out !== exp_we) begin
                failures++;
                $display("FAIL rand_we cyc=%0d got=%b required=%b", cyc, bus.rf_we_out, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (bus.rf_waddr_out !== exp_waddr || bus.rf_wdata_out !== exp_wdata) begin
                    failures++;
                    $display("FAIL rand_wdata cyc=%0d got addr=%0d data=%h required addr=%0d data=%h",
                             cyc, bus.rf_waddr_out, bus.rf_wdata_out, exp_waddr, exp_wdata);
                end
            end
            checks++;
            if (bus.pipe_stall_out !== exp_stall) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got=%b required=%b", cyc, bus.pipe_stall_out, exp_stall);
            end
            checks++;
            if (bus.ll_ready_out !== exp_ready()) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b required=%b", cyc, bus.ll_ready_out, exp_ready());
            end
            reset = ($urandom_range(0, 99) == 0);
            if (!exp_stall || reset) begin
                bus.wb_valid_in     = ($urandom_range(0, 9) < 7);
                bus.wb_reg_write_in = ($urandom_range(0, 9) < 9);
                bus.wb_dest_in      = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
                bus.wb_data_in      = {$urandom, $urandom};
            end
            if (!ll_pending) begin
                bus.ll_valid_in = ($urandom_range(0, 9) < 4);
                bus.ll_dest_in  = ($urandom_range(0, 7) == 0) ? 5'd0 : RW'($urandom_range(1, 31));
                bus.ll_data_in  = {$urandom, $urandom};
            end
            #1;
            ll_pending = bus.ll_valid_in && !exp_ready();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        $display("test_random done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_pipe_write();
        test_ll_latency();
        test_full_drain();
        test_age();
        test_dest_zero();
        test_reset_in_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
